// File: rtl/cheat_bank.sv
// Parametrised ROM/WRAM patch engine: N address/data slots, priority winner, atomic enable commit, hit counters.
// Define CHEAT_COMPARE_EN to build the per-slot compare-byte (conditional) patch.
module cheat_bank #(
   parameter int NUM_SLOTS = 16,
   parameter int IDX_W     = 5,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [23:0]      SNES_ADDR,
   input  logic             SNES_cycle_start,
   input  logic             SNES_rd_strobe,
   input  logic [7:0]       rom_data_in,
   input  logic             rom_data_valid,
   input  logic             cheat_enable,
   input  logic             pgm_we,
   input  logic [1:0]       pgm_sel,
   input  logic [IDX_W-1:0] pgm_idx,
   input  logic [31:0]      pgm_in,
   input  logic [IDX_W-1:0] stat_idx,
   output logic [CNT_W-1:0] stat_count,
   output logic [7:0]       data_out,
   output logic             cheat_hit,
   output logic [IDX_W-1:0] hit_idx
);

   logic [NUM_SLOTS-1:0]            staged_q, staged_d;
   logic [NUM_SLOTS-1:0]            active_q, active_d;
   logic                            pend_q, pend_d;
   logic [NUM_SLOTS-1:0]            sel_oh;
   logic                            idx_ok;
   logic [NUM_SLOTS-1:0]            qual;
   logic [NUM_SLOTS-1:0][7:0]       slot_data;
   logic [NUM_SLOTS-1:0][CNT_W-1:0] slot_cnt;
   logic                            win_vld;
   logic [IDX_W-1:0]                win_idx;
   logic [7:0]                      win_data;
   logic [NUM_SLOTS-1:0]            win_oh;
   logic                            cnt_inc;
   logic [CNT_W-1:0]                stat_q, stat_d;

   assign idx_ok = |sel_oh;

   // Staged enables move to the active set only on a bus-cycle boundary.
   always_comb begin
      staged_d = staged_q;
      active_d = active_q;
      pend_d   = pend_q;
      if (pgm_we && pgm_sel == 2'd2) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            if (sel_oh[i]) staged_d[i] = pgm_in[0];
      end
      if (SNES_cycle_start && pend_q) begin
         active_d = staged_d;
         pend_d   = 1'b0;
      end
      if (pgm_we && pgm_sel == 2'd3 && idx_ok) pend_d = 1'b1;
   end

   // Scan high to low so the lowest qualifying slot is the one left standing.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_data = 8'h00;
      win_oh   = '0;
      for (int i = NUM_SLOTS-1; i >= 0; i--) begin
         if (qual[i]) begin
            win_vld   = 1'b1;
            win_idx   = IDX_W'(i);
            win_data  = slot_data[i];
            win_oh    = '0;
            win_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      stat_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (stat_idx == IDX_W'(i)) stat_d = slot_cnt[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         staged_q <= '0;
         active_q <= '0;
         pend_q   <= 1'b0;
         stat_q   <= '0;
      end else begin
         staged_q <= staged_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         stat_q   <= stat_d;
      end
   end

   assign cnt_inc    = SNES_rd_strobe & cheat_hit;
   assign cheat_hit  = cheat_enable & win_vld;
   assign data_out   = win_data;
   assign hit_idx    = win_idx;
   assign stat_count = stat_q;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      logic [23:0]      addr_q;
      logic [7:0]       data_q;
      logic             match_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             wr_ad;

      assign sel_oh[i] = (pgm_idx == IDX_W'(i));
      assign wr_ad     = pgm_we & (pgm_sel == 2'd0) & sel_oh[i];

      // Patch contents are don't-care until the slot is enabled, so no reset.
      always_ff @(posedge clk) begin
         if (wr_ad) begin
            addr_q <= pgm_in[31:8];
            data_q <= pgm_in[7:0];
         end
      end

      // A reprogram of the slot takes precedence over a same-clk increment.
      always_comb begin
         cnt_d = cnt_q;
         if (wr_ad)
            cnt_d = '0;
         else if (cnt_inc && win_oh[i] && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            match_q <= active_q[i] & (SNES_ADDR == addr_q);
            cnt_q   <= cnt_d;
         end
      end

`ifdef CHEAT_COMPARE_EN
      logic [7:0] cmp_q;
      logic       cmp_en_q, cmp_ok_q, wr_cmp;

      assign wr_cmp = pgm_we & (pgm_sel == 2'd1) & sel_oh[i];

      always_ff @(posedge clk) begin
         if (wr_cmp) cmp_q <= pgm_in[7:0];
      end

      // Valid data in the same clk as a cycle start belongs to the new cycle.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cmp_en_q <= 1'b0;
            cmp_ok_q <= 1'b0;
         end else begin
            if (wr_cmp) cmp_en_q <= pgm_in[8];
            if (rom_data_valid && rom_data_in == cmp_q)
               cmp_ok_q <= 1'b1;
            else if (SNES_cycle_start)
               cmp_ok_q <= 1'b0;
         end
      end

      assign qual[i] = match_q & (~cmp_en_q | cmp_ok_q);
`else
      assign qual[i] = match_q;
`endif

      assign slot_data[i] = data_q;
      assign slot_cnt[i]  = cnt_q;
   end

`ifndef CHEAT_COMPARE_EN
   logic unused_rom;
   assign unused_rom = ^{rom_data_in, rom_data_valid};
`endif

endmodule
